// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the instruction fetch sequencer, the PC register and
// the instruction memory: default bus widths, the latency counter width and
// the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package fetch_sequencer_pkg;

    // Default widths shared with the PC register and instruction memory.
    localparam int ADDR_W_DEF  = 10;
    localparam int INSTR_W_DEF = 8;

    // Wide enough for the largest legal memory latency (7).
    localparam int LAT_CNT_W   = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADDR  = 3'd2,
        WAIT  = 3'd3,
        ISSUE = 3'd4,
        JUMP  = 3'd5,
        HALT  = 3'd6
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_lat_counter.sv
// ---------------------------------------------------------------------------
// fetch_lat_counter
// Down-counter that times the instruction-memory read latency.
//   clk, rst : clock, asynchronous active-high reset
//   start    : one-cycle pulse, loads IMEM_LAT (the cycle before the strobe)
//   done     : count has reached zero; read data is valid this cycle when the
//              fetcher is waiting on memory
// IMEM_LAT must lie in 1..7.
// ---------------------------------------------------------------------------
module fetch_lat_counter
    import fetch_sequencer_pkg::*;
#(
    parameter int IMEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    logic [LAT_CNT_W-1:0] cnt_q;
    logic [LAT_CNT_W-1:0] cnt_d;

    // The counter is loaded on the edge that issues the read strobe, so the
    // strobe cycle sees IMEM_LAT and the data-valid cycle sees zero.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = LAT_CNT_W'(IMEM_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch sequencer: controls the PC register, reads one word per PC
// value from instruction memory and hands it to the control unit.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   run                 : start pulse, honoured in IDLE or HALT only
//   pc_rdirect          : PC direct-read value
//   pc_overflow         : PC wrapped from all-ones to zero
//   pc_rin/pc_en_write  : PC load value / load enable (pc_rin is 0 when idle)
//   pc_en_read          : PC shared-bus read enable, always 0
//   pc_en_direct_read   : PC direct-read enable
//   pc_inc              : PC increment request
//   imem_addr/rd_en     : memory address and one-cycle read strobe
//   imem_data           : memory data, valid IMEM_LAT cycles after the strobe
//   ir_out/ir_valid     : fetched word and its valid flag
//   cu_ready            : control unit accepts ir_out
//   jump_req/target     : redirect on acceptance
//   halt_req            : stop after acceptance
//   halted              : high in HALT
//   wrap_flag           : sticky PC-overflow status, cleared by reset or run
//   dbg_state           : current FSM state
//
// Handshake: a word is transferred in every cycle where ir_valid and cu_ready
// are both high; ir_valid and ir_out hold steady until that cycle, and
// jump_req/halt_req are only looked at in that cycle.
//
// Optional build macro FETCH_WRAP_HALT_EN: once the PC has wrapped, the
// fetcher halts instead of fetching from the wrapped address.
//
// All PC controls are registered; the PC register acts on the negedge of the
// same cycle, so pc_rdirect already reflects a load/increment by the end of
// the cycle that requested it.
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                INSTR_W    = INSTR_W_DEF,
    parameter int                IMEM_LAT   = 2,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [ADDR_W-1:0]  pc_rdirect,
    input  logic               pc_overflow,
    output logic [ADDR_W-1:0]  pc_rin,
    output logic               pc_en_write,
    output logic               pc_en_read,
    output logic               pc_en_direct_read,
    output logic               pc_inc,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    input  logic               cu_ready,
    input  logic               jump_req,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               halt_req,
    output logic               halted,
    output logic               wrap_flag,
    output fetch_state_e       dbg_state
);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_rin_q, pc_rin_d;
    logic                pc_en_write_q, pc_en_write_d;
    logic                pc_en_direct_read_q, pc_en_direct_read_d;
    logic                pc_inc_q, pc_inc_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic                imem_rd_en_q, imem_rd_en_d;
    logic [INSTR_W-1:0]  ir_out_q, ir_out_d;
    logic                ir_valid_q, ir_valid_d;
    logic                halted_q, halted_d;
    logic                wrap_flag_q, wrap_flag_d;
    logic                halt_pend_q, halt_pend_d;
    logic                lat_start;
    logic                lat_done;
    logic                wrap_stop;

`ifdef FETCH_WRAP_HALT_EN
    // pc_overflow is included so the increment that wraps the PC is caught in
    // the same ADDR cycle, before a read of address 0 is issued.
    assign wrap_stop = wrap_flag_q | pc_overflow;
`else
    assign wrap_stop = 1'b0;
`endif

    fetch_lat_counter #(
        .IMEM_LAT (IMEM_LAT)
    ) u_lat_counter (
        .clk   (clk),
        .rst   (reset),
        .start (lat_start),
        .done  (lat_done)
    );

    always_comb begin
        state_d     = state_q;
        imem_addr_d = imem_addr_q;
        ir_out_d    = ir_out_q;
        halt_pend_d = halt_pend_q;
        wrap_flag_d = wrap_flag_q | pc_overflow;
        lat_start   = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (run) begin
                    state_d     = LOAD;
                    wrap_flag_d = 1'b0;
                end
            end
            LOAD: begin
                state_d = ADDR;
            end
            ADDR: begin
                if (wrap_stop) begin
                    state_d = HALT;
                end else begin
                    state_d     = WAIT;
                    imem_addr_d = pc_rdirect;
                    lat_start   = 1'b1;
                end
            end
            WAIT: begin
                if (lat_done) begin
                    ir_out_d = imem_data;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (cu_ready) begin
                    if (jump_req) begin
                        // The jump load always happens; a concurrent halt is
                        // remembered and taken after JUMP.
                        state_d     = JUMP;
                        halt_pend_d = halt_req;
                    end else if (halt_req || wrap_stop) begin
                        // No increment on a halt: the next run reloads the PC.
                        state_d = HALT;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            JUMP: begin
                state_d     = halt_pend_q ? HALT : ADDR;
                halt_pend_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are decoded from the state being entered, so
        // each control is high for exactly the cycle its state occupies.
        pc_en_write_d       = (state_d == LOAD) || (state_d == JUMP);
        pc_rin_d            = '0;
        if (state_d == LOAD) begin
            pc_rin_d = START_ADDR;
        end else if (state_d == JUMP) begin
            pc_rin_d = jump_target;
        end
        // The increment shares the following ADDR cycle: the PC steps on the
        // negedge and the new value is captured into imem_addr at cycle end.
        pc_inc_d            = (state_q == ISSUE) && (state_d == ADDR);
        pc_en_direct_read_d = (state_d == ADDR);
        imem_rd_en_d        = lat_start;
        ir_valid_d          = (state_d == ISSUE);
        halted_d            = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= IDLE;
            pc_rin_q            <= '0;
            pc_en_write_q       <= 1'b0;
            pc_en_direct_read_q <= 1'b0;
            pc_inc_q            <= 1'b0;
            imem_addr_q         <= '0;
            imem_rd_en_q        <= 1'b0;
            ir_out_q            <= '0;
            ir_valid_q          <= 1'b0;
            halted_q            <= 1'b0;
            wrap_flag_q         <= 1'b0;
            halt_pend_q         <= 1'b0;
        end else begin
            state_q             <= state_d;
            pc_rin_q            <= pc_rin_d;
            pc_en_write_q       <= pc_en_write_d;
            pc_en_direct_read_q <= pc_en_direct_read_d;
            pc_inc_q            <= pc_inc_d;
            imem_addr_q         <= imem_addr_d;
            imem_rd_en_q        <= imem_rd_en_d;
            ir_out_q            <= ir_out_d;
            ir_valid_q          <= ir_valid_d;
            halted_q            <= halted_d;
            wrap_flag_q         <= wrap_flag_d;
            halt_pend_q         <= halt_pend_d;
        end
    end

    assign pc_rin            = pc_rin_q;
    assign pc_en_write       = pc_en_write_q;
    assign pc_en_read        = 1'b0;
    assign pc_en_direct_read = pc_en_direct_read_q;
    assign pc_inc            = pc_inc_q;
    assign imem_addr         = imem_addr_q;
    assign imem_rd_en        = imem_rd_en_q;
    assign ir_out            = ir_out_q;
    assign ir_valid          = ir_valid_q;
    assign halted            = halted_q;
    assign wrap_flag         = wrap_flag_q;
    assign dbg_state         = state_q;

endmodule
